// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle control unit and the datapath.
// The controller is the master: it drives every select and enable.
interface mc_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        FPUWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite,
    output IRWrite, FPUWrite, AdrSrc,
    output RegSrc, ALUSrcA, ALUSrcB,
    output ResultSrc, ImmSrc, ALUControl
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite,
    input  IRWrite, FPUWrite, AdrSrc,
    input  RegSrc, ALUSrcA, ALUSrcB,
    input  ResultSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: decoder, main FSM, condition check,
// NZCV flags register and registered condition-pass bit.
module mc_controller (
  input  logic clk,
  input  logic reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  state_t     state;
  state_t     view;
  logic       cond_ex;
  logic [3:0] flags;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       s_bit;
  logic       ld_bit;
  logic       rd15;
  logic       is_mul;
  logic       run;

  logic [2:0] alu_ctl;
  logic       no_write;
  logic [1:0] flag_w;
  logic       cond_ok;

  logic       unused_bits;

  assign cond   = bus.Instr[31:28];
  assign op     = bus.Instr[27:26];
  assign funct  = bus.Instr[25:20];
  assign cmd    = funct[4:1];
  assign s_bit  = funct[0];
  assign ld_bit = funct[0];
  assign rd15   = (bus.Instr[15:12] == 4'hF);
  assign is_mul = (op == 2'b00) && (cmd == 4'b0000)
               && (bus.Instr[7:4] == 4'b1001)
               && !funct[5];
  assign run    = !reset;

  assign unused_bits = ^{bus.Instr[19:16],
                         bus.Instr[11:8],
                         bus.Instr[3:0]};

  // ALU and flag-write decode for data-processing
  always_comb begin
    alu_ctl  = ALU_ADD;
    no_write = 1'b0;
    flag_w   = 2'b00;
    if (op == 2'b00) begin
      case (cmd)
        4'b0100: begin
          alu_ctl = ALU_ADD;
          flag_w  = {s_bit, s_bit};
        end
        4'b0010: begin
          alu_ctl = ALU_SUB;
          flag_w  = {s_bit, s_bit};
        end
        4'b1100: begin
          alu_ctl = ALU_ORR;
          flag_w  = {s_bit, 1'b0};
        end
        4'b1010: begin
          alu_ctl  = ALU_SUB;
          no_write = 1'b1;
          flag_w   = {s_bit, s_bit};
        end
        4'b0000: begin
          if (is_mul) begin
            alu_ctl = ALU_MUL;
          end else begin
            alu_ctl = ALU_AND;
            flag_w  = {s_bit, 1'b0};
          end
        end
        default: begin
          alu_ctl  = ALU_ADD;
          no_write = 1'b1;
          flag_w   = {s_bit, 1'b0};
        end
      endcase
    end
  end

  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = fz;
      4'h1: cond_ok = !fz;
      4'h2: cond_ok = fc;
      4'h3: cond_ok = !fc;
      4'h4: cond_ok = fn;
      4'h5: cond_ok = !fn;
      4'h6: cond_ok = fv;
      4'h7: cond_ok = !fv;
      4'h8: cond_ok = fc && !fz;
      4'h9: cond_ok = !fc || fz;
      4'hA: cond_ok = (fn == fv);
      4'hB: cond_ok = (fn != fv);
      4'hC: cond_ok = !fz && (fn == fv);
      4'hD: cond_ok = fz || (fn != fv);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      flags   <= 4'h0;
      cond_ex <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          cond_ex <= cond_ok;
          unique case (op)
            2'b00: state <= funct[5] ? S_EXECI
                                     : S_EXECR;
            2'b01: state <= S_MEMADR;
            2'b10: state <= S_BRANCH;
            2'b11: state <= S_FETCH;
          endcase
        end
        S_MEMADR: state <= ld_bit ? S_MEMRD
                                  : S_MEMWR;
        S_MEMRD:  state <= S_MEMWB;
        S_EXECR, S_EXECI: begin
          state <= S_ALUWB;
          if (cond_ex && flag_w[1])
            flags[3:2] <= bus.ALUFlags[3:2];
          if (cond_ex && flag_w[0])
            flags[1:0] <= bus.ALUFlags[1:0];
        end
        S_MEMWB, S_MEMWR,
        S_ALUWB, S_BRANCH: state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Reset shows FETCH selects with every enable held low
  assign view = reset ? S_FETCH : state;

  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.FPUWrite   = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 2'b01;
    bus.ALUSrcB    = 2'b10;
    bus.ResultSrc  = 2'b10;
    bus.ALUControl = ALU_ADD;
    bus.ImmSrc     = op;
    bus.RegSrc     = {(op == 2'b01) && !ld_bit,
                      (op == 2'b10)};
    unique case (view)
      S_FETCH: begin
        bus.IRWrite = run;
        bus.PCWrite = run;
      end
      S_DECODE: ;
      S_MEMADR: begin
        bus.ALUSrcA = 2'b00;
        bus.ALUSrcB = 2'b01;
      end
      S_MEMRD: begin
        bus.AdrSrc    = 1'b1;
        bus.ResultSrc = 2'b00;
      end
      S_MEMWR: begin
        bus.AdrSrc    = 1'b1;
        bus.ResultSrc = 2'b00;
        bus.MemWrite  = cond_ex;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = cond_ex && !rd15;
        bus.PCWrite   = cond_ex && rd15;
      end
      S_EXECR: begin
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = alu_ctl;
      end
      S_EXECI: begin
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_ctl;
      end
      S_ALUWB: begin
        bus.ResultSrc = 2'b00;
        bus.RegWrite  = cond_ex && !no_write
                     && !rd15;
        bus.PCWrite   = cond_ex && !no_write
                     && rd15;
      end
      S_BRANCH: begin
        bus.ALUSrcA = 2'b00;
        bus.ALUSrcB = 2'b01;
        bus.PCWrite = cond_ex;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: driver queues per-cycle
// expectations, a negedge monitor pops and compares.
module tb_mc_controller;

  localparam int F   = 0;
  localparam int D   = 1;
  localparam int MA  = 2;
  localparam int MR  = 3;
  localparam int MWB = 4;
  localparam int MW  = 5;
  localparam int ER  = 6;
  localparam int EI  = 7;
  localparam int AW  = 8;
  localparam int BR  = 9;
  localparam int RST = 10;

  typedef struct {
    string       name;
    logic [18:0] val;
    logic [18:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [18:0] act;
      e = q.pop_front();
      act = {bus.PCWrite, bus.MemWrite,
             bus.RegWrite, bus.IRWrite,
             bus.FPUWrite, bus.AdrSrc,
             bus.RegSrc, bus.ALUSrcA,
             bus.ALUSrcB, bus.ResultSrc,
             bus.ImmSrc, bus.ALUControl};
      checks++;
      if (((act ^ e.val) & e.mask) !== 19'd0) begin
        errors++;
        $display("FAIL %s got=%05h want=%05h mask=%05h",
                 e.name, act, e.val, e.mask);
      end
    end
  end

  // Expected outputs for one cycle in state st
  task automatic step(string n, int st,
                      logic [1:0] rs, logic [1:0] imm,
                      logic [2:0] alu, logic pcw,
                      logic mw, logic rw);
    exp_t e;
    e.name = n;
    e.val  = '0;
    e.mask = 19'h7C000 | 19'h01800 | 19'h00018;
    e.val[18]    = pcw;
    e.val[17]    = mw;
    e.val[16]    = rw;
    e.val[15]    = (st == F);
    e.val[12:11] = rs;
    e.val[4:3]   = imm;
    case (st)
      F, RST, D: begin
        e.val[13] = 1'b0;      e.mask[13]   = 1'b1;
        e.val[10:9] = 2'b01;   e.mask[10:9] = 2'b11;
        e.val[8:7]  = 2'b10;   e.mask[8:7]  = 2'b11;
        e.val[6:5]  = 2'b10;   e.mask[6:5]  = 2'b11;
        e.val[2:0]  = 3'b000;  e.mask[2:0]  = 3'b111;
        if (st == D) e.mask[13] = 1'b0;
      end
      MA, BR: begin
        e.val[10:9] = 2'b00;   e.mask[10:9] = 2'b11;
        e.val[8:7]  = 2'b01;   e.mask[8:7]  = 2'b11;
        e.val[2:0]  = 3'b000;  e.mask[2:0]  = 3'b111;
        if (st == BR) begin
          e.val[6:5] = 2'b10;  e.mask[6:5]  = 2'b11;
        end
      end
      MR, MW: begin
        e.val[13]   = 1'b1;    e.mask[13]   = 1'b1;
        e.val[6:5]  = 2'b00;   e.mask[6:5]  = 2'b11;
      end
      MWB: begin
        e.val[6:5]  = 2'b01;   e.mask[6:5]  = 2'b11;
      end
      ER, EI: begin
        e.val[10:9] = 2'b00;   e.mask[10:9] = 2'b11;
        e.val[8:7]  = (st == EI) ? 2'b01 : 2'b00;
        e.mask[8:7] = 2'b11;
        e.val[2:0]  = alu;     e.mask[2:0]  = 3'b111;
      end
      AW: begin
        e.val[6:5]  = 2'b00;   e.mask[6:5]  = 2'b11;
      end
      default: ;
    endcase
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_dp(string n, logic [31:0] ins,
                        logic immf, logic [2:0] alu,
                        logic [3:0] fl, logic pcw,
                        logic rw);
    bus.Instr = ins;
    bus.ALUFlags = 4'h0;
    step({n, ".F"}, F, 2'b00, 2'b00, 3'd0, 1, 0, 0);
    step({n, ".D"}, D, 2'b00, 2'b00, 3'd0, 0, 0, 0);
    bus.ALUFlags = fl;
    step({n, ".X"}, immf ? EI : ER, 2'b00, 2'b00,
         alu, 0, 0, 0);
    bus.ALUFlags = 4'h0;
    step({n, ".WB"}, AW, 2'b00, 2'b00, 3'd0,
         pcw, 0, rw);
  endtask

  task automatic run_b(string n, logic [31:0] ins,
                       logic taken);
    bus.Instr = ins;
    step({n, ".F"}, F, 2'b01, 2'b10, 3'd0, 1, 0, 0);
    step({n, ".D"}, D, 2'b01, 2'b10, 3'd0, 0, 0, 0);
    step({n, ".B"}, BR, 2'b01, 2'b10, 3'd0,
         taken, 0, 0);
  endtask

  task automatic run_mem(string n, logic [31:0] ins,
                         logic ld, logic pass,
                         logic rd15);
    logic [1:0] rs;
    rs = ld ? 2'b00 : 2'b10;
    bus.Instr = ins;
    step({n, ".F"}, F, rs, 2'b01, 3'd0, 1, 0, 0);
    step({n, ".D"}, D, rs, 2'b01, 3'd0, 0, 0, 0);
    step({n, ".MA"}, MA, rs, 2'b01, 3'd0, 0, 0, 0);
    if (ld) begin
      step({n, ".MR"}, MR, rs, 2'b01, 3'd0, 0, 0, 0);
      step({n, ".WB"}, MWB, rs, 2'b01, 3'd0,
           pass & rd15, 0, pass & ~rd15);
    end else begin
      step({n, ".MW"}, MW, rs, 2'b01, 3'd0,
           0, pass, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.Instr = 32'hE0821003;
    bus.ALUFlags = 4'h0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      step("rst", RST, 2'b00, 2'b00, 3'd0, 0, 0, 0);
    reset = 1'b0;

    run_dp("add", 32'hE0821003, 0, 3'b000, 4'h0, 0, 1);
    run_dp("subs", 32'hE2500001, 1, 3'b001,
           4'b0100, 0, 1);
    run_b("beq_z1", 32'h0A000002, 1);
    run_dp("cmp", 32'hE3500000, 1, 3'b001,
           4'b0010, 0, 0);
    run_b("beq_z0", 32'h0A000002, 0);
    run_dp("mul", 32'hE0010392, 0, 3'b100,
           4'b1111, 0, 1);
    run_b("beq_mul", 32'h0A000002, 0);
    run_b("bcs_mul", 32'h2A000002, 1);
    run_dp("nv", 32'hF0821003, 0, 3'b000, 4'h0, 0, 0);
    run_dp("addpc", 32'hE082F003, 0, 3'b000,
           4'h0, 1, 0);
    run_dp("orrs", 32'hE1921003, 0, 3'b011,
           4'b0101, 0, 1);
    run_b("beq_orr", 32'h0A000002, 1);
    run_b("bvs_orr", 32'h6A000002, 0);
    run_b("bcs_orr", 32'h2A000002, 1);
    run_mem("ldr", 32'hE591F000, 1, 1, 1);
    run_dp("cmp_z1", 32'hE3500000, 1, 3'b001,
           4'b0100, 0, 0);
    run_mem("strne_z1", 32'h15812000, 0, 0, 0);
    run_dp("cmp_z0", 32'hE3500000, 1, 3'b001,
           4'b0000, 0, 0);
    run_mem("strne_z0", 32'h15812000, 0, 1, 0);

    bus.Instr = 32'hE5812000;
    step("str.F", F, 2'b10, 2'b01, 3'd0, 1, 0, 0);
    step("str.D", D, 2'b10, 2'b01, 3'd0, 0, 0, 0);
    step("str.MA", MA, 2'b10, 2'b01, 3'd0, 0, 0, 0);
    reset = 1'b1;
    step("str.rst", RST, 2'b10, 2'b01, 3'd0, 0, 0, 0);
    reset = 1'b0;
    run_mem("str", 32'hE5812000, 0, 1, 0);

    bus.Instr = 32'hEC000000;
    step("nop.F", F, 2'b00, 2'b11, 3'd0, 1, 0, 0);
    step("nop.D", D, 2'b00, 2'b11, 3'd0, 0, 0, 0);
    step("nop.F2", F, 2'b00, 2'b11, 3'd0, 1, 0, 0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
